sobel_magnitude: RTL and testbench

- Downstream stage of the Sobel convolver pair: one convolver computes Gx, the other Gy, both fed the same activation stream.
- Combines Gx and Gy into a gradient magnitude |Gx|+|Gy|, then thresholds it into an edge bit.
- Tags each output pixel with row/column position and end-of-line/end-of-frame markers.
- Buffers results in a small FIFO with valid/ready output and back-pressures the convolvers through their ce input.

---
 rtl/sobel_pkg.sv | 34 +++
 rtl/sobel_magnitude_sync_fifo.sv | 64 ++++++
 rtl/sobel_magnitude.sv | 174 +++++++++++++++++
 tb/tb_sobel_magnitude.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel magnitude stage: default widths, FIFO entry layout, abs helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sobel_pkg;

  // Default data format: 16-bit signed fixed point with 12 fractional bits
  localparam int N_DEF = 16;
  localparam int Q_DEF = 12;

  // FIFO entry = {eof, eol, edge, mag[N-1:0]}; tag offsets are relative to bit N
  localparam int ENT_MAG_LSB  = 0;
  localparam int ENT_EDGE_OFS = 0;
  localparam int ENT_EOL_OFS  = 1;
  localparam int ENT_EOF_OFS  = 2;
  localparam int ENT_TAG_W    = 3;
  localparam int ENTRY_W_DEF  = N_DEF + ENT_TAG_W;

  // Saturating absolute value of a w-bit two's complement number that the caller
  // has sign-extended to 32 bits. The most negative value maps to 2^(w-1)-1 so
  // the result always fits in w-1 unsigned bits.
  function automatic logic [31:0] sat_abs(input logic [31:0] v, input int w);
    logic [31:0] pos_max;
    logic [31:0] mag;
    pos_max = (32'd1 << (w - 1)) - 32'd1;
    if (v[31]) begin
      mag = ~v + 32'd1;
      if (mag > pos_max) mag = pos_max;
    end else begin
      mag = v;
    end
    return mag;
  endfunction

endpackage

// File: rtl/sobel_magnitude_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on rd_data whenever empty is low.
// Latency: a write at edge E is visible on rd_data right after E when the FIFO was empty.
// Backpressure: write at full is ignored unless a read happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       global_rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer/count update; a full FIFO still accepts a write when it is popped on the same edge
  always_comb begin
    pop      = rd_en & ~empty;
    push     = wr_en & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  // Control state registers
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sobel_magnitude.sv
// Sobel gradient magnitude |Gx|+|Gy| with threshold edge bit, row/col tags and output FIFO.
// Latency: 3 edges from input sampling to out_valid when the FIFO is empty.
// Backpressure: out_valid/out_ready at the output; ce_out throttles the convolvers (pipeline itself never stalls).
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int M     = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                global_rst_n,
  input  logic signed [N-1:0] gx,
  input  logic signed [N-1:0] gy,
  input  logic                valid_gx,
  input  logic                valid_gy,
  input  logic [N-1:0]        thr,
  output logic                ce_out,
  output logic [N-1:0]        out_mag,
  output logic                out_edge,
  output logic                out_eol,
  output logic                out_eof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_done,
  output logic                overflow,
  output logic                sync_err
);

  // Q only documents the fixed-point format; the magnitude keeps it unchanged
  localparam int unused_q_frac = Q;

  localparam int W        = N + ENT_TAG_W;
  localparam int EDGE_POS = N + ENT_EDGE_OFS;
  localparam int EOL_POS  = N + ENT_EOL_OFS;
  localparam int EOF_POS  = N + ENT_EOF_OFS;
  localparam int CW       = (M > 1) ? $clog2(M) : 1;
  localparam int AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST     = CW'(M - 1);
  // Leaves room for two pixels in flight plus the ce register delay
  localparam logic [AW:0]   CE_LIMIT = (AW+1)'(DEPTH - 4);

  // Stage 1: absolute values and threshold
  logic           s1_vld_q, s1_vld_d;
  logic [N-2:0]   ax_q, ax_d;
  logic [N-2:0]   ay_q, ay_d;
  logic [N-1:0]   thr1_q, thr1_d;
  logic           sample;

  // Stage 2: tagged FIFO entry
  logic           s2_vld_q, s2_vld_d;
  logic [W-1:0]   ent2_q, ent2_d;
  logic [CW-1:0]  col_q, col_d;
  logic [CW-1:0]  row_q, row_d;
  logic [N-1:0]   mag2;
  logic           edge2, eol2, eof2;

  // Status and flow control
  logic           sync_err_q, sync_err_d;
  logic           overflow_q, overflow_d;
  logic           ce_q, ce_d;
  logic           frame_done_q, frame_done_d;

  // FIFO interface
  logic           fifo_rd_en;
  logic [W-1:0]   fifo_rd_data;
  logic           fifo_full, fifo_empty;
  logic [AW:0]    fifo_count;

  // Stage 1: sample only when both convolvers agree; hold data otherwise to avoid needless toggling
  always_comb begin
    sample   = valid_gx & valid_gy;
    s1_vld_d = sample;
    ax_d     = ax_q;
    ay_d     = ay_q;
    thr1_d   = thr1_q;
    if (sample) begin
      ax_d   = (N-1)'(sat_abs(32'(gx), N));
      ay_d   = (N-1)'(sat_abs(32'(gy), N));
      thr1_d = thr;
    end
  end

  // Stage 2: magnitude, edge decision, position tags and row/col counters
  always_comb begin
    mag2     = N'(ax_q) + N'(ay_q);
    edge2    = (mag2 >= thr1_q);
    eol2     = (col_q == LAST);
    eof2     = eol2 & (row_q == LAST);
    s2_vld_d = s1_vld_q;
    ent2_d   = ent2_q;
    col_d    = col_q;
    row_d    = row_q;
    if (s1_vld_q) begin
      ent2_d[N-1:ENT_MAG_LSB] = mag2;
      ent2_d[EDGE_POS]        = edge2;
      ent2_d[EOL_POS]         = eol2;
      ent2_d[EOF_POS]         = eof2;
      if (eol2) begin
        col_d = '0;
        row_d = eof2 ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Sticky error flags, registered ce and end-of-frame pulse
  always_comb begin
    fifo_rd_en   = out_ready & ~fifo_empty;
    sync_err_d   = sync_err_q | (valid_gx ^ valid_gy);
    overflow_d   = overflow_q | (s2_vld_q & fifo_full & ~fifo_rd_en);
    ce_d         = (fifo_count <= CE_LIMIT);
    frame_done_d = fifo_rd_en & fifo_rd_data[EOF_POS];
  end

  // All pipeline and status registers
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      s1_vld_q     <= 1'b0;
      ax_q         <= '0;
      ay_q         <= '0;
      thr1_q       <= '0;
      s2_vld_q     <= 1'b0;
      ent2_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      sync_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
      ce_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      ax_q         <= ax_d;
      ay_q         <= ay_d;
      thr1_q       <= thr1_d;
      s2_vld_q     <= s2_vld_d;
      ent2_q       <= ent2_d;
      col_q        <= col_d;
      row_q        <= row_d;
      sync_err_q   <= sync_err_d;
      overflow_q   <= overflow_d;
      ce_q         <= ce_d;
      frame_done_q <= frame_done_d;
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .wr_en        (s2_vld_q),
    .wr_data      (ent2_q),
    .rd_en        (fifo_rd_en),
    .rd_data      (fifo_rd_data),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count)
  );

  assign out_mag    = fifo_rd_data[N-1:ENT_MAG_LSB];
  assign out_edge   = fifo_rd_data[EDGE_POS];
  assign out_eol    = fifo_rd_data[EOL_POS];
  assign out_eof    = fifo_rd_data[EOF_POS];
  assign out_valid  = ~fifo_empty;
  assign ce_out     = ce_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_sobel_magnitude.sv
module tb_sobel_magnitude;

  logic        clk;
  logic        global_rst_n;
  logic [15:0] gx, gy, thr;
  logic        valid_gx, valid_gy;
  logic        ce_out;
  logic [15:0] out_mag;
  logic        out_edge, out_eol, out_eof, out_valid, out_ready;
  logic        frame_done, overflow, sync_err;

  sobel_magnitude #(.N(16), .Q(12), .M(8), .DEPTH(16)) dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .gx           (gx),
    .gy           (gy),
    .valid_gx     (valid_gx),
    .valid_gy     (valid_gy),
    .thr          (thr),
    .ce_out       (ce_out),
    .out_mag      (out_mag),
    .out_edge     (out_edge),
    .out_eol      (out_eol),
    .out_eof      (out_eof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .sync_err     (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Occupancy / flag model, advanced once per clock by cyc()
  int m_cnt;
  bit m_p1, m_p2, m_ovf, m_sync, m_ce;

  typedef struct {
    logic [15:0] gx;
    logic [15:0] gy;
    logic [15:0] thr;
    logic [15:0] mag;
    logic        edg;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_clear();
    m_cnt = 0; m_p1 = 0; m_p2 = 0; m_ovf = 0; m_sync = 0; m_ce = 1;
  endtask

  // Drive one cycle of inputs, update the model for the coming edge, then step past it
  task automatic cyc(input bit vx, input bit vy, input bit rdy, input logic [15:0] x, input logic [15:0] y);
    bit pop;
    bit ce_n;
    valid_gx = vx; valid_gy = vy; gx = x; gy = y; out_ready = rdy;
    pop  = rdy && (m_cnt > 0);
    ce_n = (m_cnt <= 12);
    if (m_p2) begin
      if (m_cnt == 16 && !pop) m_ovf = 1;
      else m_cnt++;
    end
    if (pop) m_cnt--;
    m_p2 = m_p1;
    m_p1 = vx & vy;
    if (vx ^ vy) m_sync = 1;
    m_ce = ce_n;
    @(posedge clk); #1;
  endtask

  task automatic chk_model(input string name);
    check({name, "_vld"}, out_valid, (m_cnt > 0));
    check({name, "_ce"}, ce_out, m_ce);
    check({name, "_ovf"}, overflow, m_ovf);
    check({name, "_sync"}, sync_err, m_sync);
  endtask

  task automatic do_reset();
    global_rst_n = 0; valid_gx = 0; valid_gy = 0; out_ready = 0;
    #1;
    @(posedge clk); #1;
    global_rst_n = 1;
    m_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int pushes;
    int n;
    bit fd_exp;
    bit v;

    vecs[0] = '{16'h1000, 16'hF000, 16'h1800, 16'h2000, 1'b1};
    vecs[1] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFE, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h8001, 16'hFFFE, 16'hFFFE, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'h0003, 16'h0002, 1'b0};
    vecs[5] = '{16'h0123, 16'hFEDC, 16'h0247, 16'h0247, 1'b1};
    vecs[6] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1};

    global_rst_n = 0; gx = 0; gy = 0; thr = 0;
    valid_gx = 0; valid_gy = 0; out_ready = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ce_out", ce_out, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sync_err", sync_err, 0);
    global_rst_n = 1;

    // Single pixels through an empty FIFO: latency, magnitude, saturation, threshold
    for (int i = 0; i < 7; i++) begin
      thr = vecs[i].thr;
      cyc(1, 1, 0, vecs[i].gx, vecs[i].gy);
      cyc(0, 0, 0, 0, 0);
      check($sformatf("vec%0d_lat_e1", i), out_valid, 0);
      cyc(0, 0, 0, 0, 0);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_mag", i), out_mag, vecs[i].mag);
      check($sformatf("vec%0d_edge", i), out_edge, vecs[i].edg);
      check($sformatf("vec%0d_eol", i), out_eol, 0);
      cyc(0, 0, 1, 0, 0);
      check($sformatf("vec%0d_popped", i), out_valid, 0);
    end

    // Mismatched valids: flagged, dropped, counters untouched (next pixel is col 7)
    thr = 0;
    cyc(1, 0, 0, 16'h0040, 0);
    check("sync_set", sync_err, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("sync_no_write", out_valid, 0);
    cyc(1, 1, 0, 16'd5, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("sync_next_valid", out_valid, 1);
    check("sync_next_mag", out_mag, 5);
    check("sync_next_eol_col7", out_eol, 1);
    check("sync_next_eof", out_eof, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("sync_sticky", sync_err, 1);

    // Full frame plus 8 pixels of the next frame, consumer always ready
    do_reset();
    acc = 0; fd_exp = 0;
    for (int c = 0; c < 80; c++) begin
      cyc(c < 72, c < 72, 1, 16'(c), 0);
      check($sformatf("frame_done_c%0d", c), frame_done, fd_exp);
      check($sformatf("frame_vld_c%0d", c), out_valid, (m_cnt > 0));
      fd_exp = 0;
      if (out_valid) begin
        check($sformatf("frame_mag_p%0d", acc), out_mag, acc);
        check($sformatf("frame_eol_p%0d", acc), out_eol, (acc % 8 == 7));
        check($sformatf("frame_eof_p%0d", acc), out_eof, (acc == 63));
        fd_exp = (acc == 63);
        acc++;
      end
    end
    check("frame_accepted", acc, 72);

    // Stalled consumer, producer obeys ce_out: FIFO fills to exactly 16, no overflow
    do_reset();
    pushes = 0;
    for (int c = 0; c < 30; c++) begin
      v = ce_out;
      cyc(v, v, 0, 16'(pushes), 0);
      if (v) pushes++;
      check($sformatf("ce_c%0d", c), ce_out, m_ce);
    end
    check("ce_pushes", pushes, 16);
    check("ce_overflow", overflow, 0);
    n = 0;
    for (int j = 0; j < 40; j++) begin
      if (!out_valid) break;
      check($sformatf("ce_drain_mag%0d", n), out_mag, n);
      cyc(0, 0, 1, 0, 0);
      n++;
    end
    check("ce_drained", n, 16);

    // Producer ignores ce_out: push+pop at full is fine, push at full without pop overflows
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1, 1, 0, 16'(k + 1), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_model("full16");
    check("full16_ovf0", overflow, 0);
    cyc(1, 1, 0, 16'd17, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("pushpop_ovf0", overflow, 0);
    check("pushpop_head", out_mag, 2);
    cyc(1, 1, 0, 16'd18, 0);
    cyc(0, 0, 0, 0, 0);
    check("ovf_before_write", overflow, 0);
    cyc(0, 0, 0, 0, 0);
    check("ovf_set", overflow, 1);
    chk_model("ovf");
    for (int j = 0; j < 16; j++) begin
      check($sformatf("ovf_drain_mag%0d", j), out_mag, j + 2);
      cyc(0, 0, 1, 0, 0);
    end
    check("ovf_drained", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame after 20 pixels with sticky flags set
    for (int k = 0; k < 20; k++) cyc(1, 1, 1, 16'(k + 1), 0);
    cyc(1, 0, 1, 0, 0);
    check("midrst_pre_sync", sync_err, 1);
    global_rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ce_out", ce_out, 1);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_sync_err", sync_err, 0);
    @(posedge clk); #1;
    global_rst_n = 1;
    m_clear();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(c < 8, c < 8, 1, 16'(c + 100), 0);
      if (out_valid) begin
        check($sformatf("midrst_mag_p%0d", acc), out_mag, acc + 100);
        check($sformatf("midrst_eol_p%0d", acc), out_eol, (acc == 7));
        check($sformatf("midrst_eof_p%0d", acc), out_eof, 0);
        acc++;
      end
    end
    check("midrst_accepted", acc, 8);
    chk_model("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
